display_scheduler: RTL and testbench

//  Time-shares the 8-digit seven-segment bank between up to NSRC 32-bit CPU observation sources
//  (PC, ALU result, write-back data, memory read data).

---
 rtl/disp_pkg.sv | 32 +++
 rtl/bcd_dabble_core.sv | 69 ++++++
 rtl/display_scheduler.sv | 209 ++++++++++++++++++++
 tb/tb_display_scheduler.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared constants and helpers for the seven-segment display scheduler.
// The optional leading-zero blanking in display_scheduler is enabled by LEADING_BLANK_EN.
package disp_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE = 3'd0;
  localparam state_t LOAD = 3'd1;
  localparam state_t CONV = 3'd2;
  localparam state_t DONE = 3'd3;
  localparam state_t WAIT = 3'd4;

  localparam logic [3:0] BCD_BLANK = 4'hF;
  localparam int NDIG     = 8;
  localparam int ACC_DIG  = 10;
  localparam int CONV_CYC = 32;

  // Double-dabble correction: every BCD digit of 5 or more gets +3 before the shift.
  function automatic logic [39:0] bcd_add3(input logic [39:0] acc);
    logic [39:0] res;
    res = acc;
    for (int d = 0; d < ACC_DIG; d++) begin
      if (acc[4*d +: 4] >= 4'd5) begin
        res[4*d +: 4] = acc[4*d +: 4] + 4'd3;
      end else begin
        res[4*d +: 4] = acc[4*d +: 4];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/bcd_dabble_core.sv
// Iterative binary-to-BCD engine: one shift-add-3 step per cycle over a 32-bit operand.
// done flags the final iteration so the caller sees the finished acc on the next cycle.
module bcd_dabble_core
  import disp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] value,
  output logic        busy,
  output logic        done,
  output logic [39:0] acc
);

  logic [31:0] shreg_q, shreg_d;
  logic [39:0] acc_q, acc_d;
  logic [4:0]  iter_q, iter_d;
  logic        busy_q, busy_d;
  logic [39:0] adj_s;
  logic        last_s;

  assign last_s = busy_q && (iter_q == 5'(CONV_CYC - 1));

  // Next-state for the shift register, BCD accumulator and iteration counter.
  always_comb begin
    adj_s   = bcd_add3(acc_q);
    shreg_d = shreg_q;
    acc_d   = acc_q;
    iter_d  = iter_q;
    busy_d  = busy_q;
    if (start) begin
      shreg_d = value;
      acc_d   = 40'd0;
      iter_d  = 5'd0;
      busy_d  = 1'b1;
    end else if (busy_q) begin
      acc_d   = {adj_s[38:0], shreg_q[31]};
      shreg_d = {shreg_q[30:0], 1'b0};
      iter_d  = iter_q + 5'd1;
      if (last_s) begin
        busy_d = 1'b0;
      end else begin
        busy_d = 1'b1;
      end
    end else begin
      busy_d = 1'b0;
    end
  end

  // Engine state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q <= 32'd0;
      acc_q   <= 40'd0;
      iter_q  <= 5'd0;
      busy_q  <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      acc_q   <= acc_d;
      iter_q  <= iter_d;
      busy_q  <= busy_d;
    end
  end

  assign busy = busy_q;
  assign done = last_s;
  assign acc  = acc_q;

endmodule

// File: rtl/display_scheduler.sv
// Selects one of NSRC 32-bit sources (manual or timed round-robin), converts it to signed BCD
// and publishes stable digits. Define LEADING_BLANK_EN to blank leading zero digits as 4'hF.
module display_scheduler
  import disp_pkg::*;
#(
  parameter int NSRC   = 4,
  parameter int DWELL  = 50_000_000,
  parameter bit SIGNED = 1'b1,
  localparam int SW    = $clog2(NSRC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NSRC*32-1:0] src_data,
  input  logic [NSRC-1:0]   src_valid,
  input  logic              auto_mode,
  input  logic [SW-1:0]     man_sel,
  input  logic              hold,
  output logic [31:0]       bcd,
  output logic              neg,
  output logic              ovf,
  output logic [SW-1:0]     cur_sel,
  output logic              upd,
  output logic              busy
);

  state_t        state_q, state_d;
  logic [31:0]   cnt_q, cnt_d;
  logic [SW-1:0] cand_q, cand_d;
  logic [SW-1:0] sel_q, sel_d;
  logic          neg_pend_q, neg_pend_d;
  logic [31:0]   bcd_q, bcd_d;
  logic          neg_q, neg_d;
  logic          ovf_q, ovf_d;
  logic [SW-1:0] cur_sel_q, cur_sel_d;
  logic          upd_q, upd_d;
  logic          busy_q, busy_d;

  logic [SW-1:0] man_clamp_s, rr_next_s, load_sel_s;
  logic [31:0]   load_word_s, load_mag_s;
  logic          load_neg_s, start_s;
  logic          core_busy_s, core_done_s, acc_ovf_s;
  logic [39:0]   core_acc_s;
  logic [31:0]   disp_bcd_s;

  // Source selection for the capture cycle, including out-of-range manual clamp.
  always_comb begin
    if (32'(man_sel) >= 32'(NSRC)) begin
      man_clamp_s = SW'(NSRC - 1);
    end else begin
      man_clamp_s = man_sel;
    end
    if (auto_mode) begin
      load_sel_s = cand_q;
    end else begin
      load_sel_s = man_clamp_s;
    end
    load_word_s = src_data[32*int'(load_sel_s) +: 32];
    if (SIGNED && load_word_s[31]) begin
      load_mag_s = ~load_word_s + 32'd1;
      load_neg_s = 1'b1;
    end else begin
      load_mag_s = load_word_s;
      load_neg_s = 1'b0;
    end
  end

  // Round-robin: first valid source after cur_sel, wrapping; the last probe is cur_sel itself.
  always_comb begin : rr_scan
    logic          found;
    logic [SW-1:0] idx;
    rr_next_s = cur_sel_q;
    found     = 1'b0;
    for (int i = 1; i <= NSRC; i++) begin
      idx = SW'((int'(cur_sel_q) + i) % NSRC);
      if (!found && src_valid[idx]) begin
        rr_next_s = idx;
        found     = 1'b1;
      end else begin
        found     = found;
      end
    end
  end

  bcd_dabble_core u_core (
    .clk   (clk),
    .rst   (rst),
    .start (start_s),
    .value (load_mag_s),
    .busy  (core_busy_s),
    .done  (core_done_s),
    .acc   (core_acc_s)
  );

  assign acc_ovf_s = |core_acc_s[39:32];

`ifdef LEADING_BLANK_EN
  // Blank every zero digit above the most significant nonzero one; never the units digit.
  always_comb begin : blank_scan
    logic lead;
    disp_bcd_s = core_acc_s[4*NDIG-1:0];
    lead       = !acc_ovf_s;
    for (int d = NDIG - 1; d >= 1; d--) begin
      if (lead && (core_acc_s[4*d +: 4] == 4'd0)) begin
        disp_bcd_s[4*d +: 4] = BCD_BLANK;
      end else begin
        lead = 1'b0;
      end
    end
  end
`else
  assign disp_bcd_s = core_acc_s[4*NDIG-1:0];
`endif

  // Scheduler FSM, dwell timer and output register next-state.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cand_d     = cand_q;
    sel_d      = sel_q;
    neg_pend_d = neg_pend_q;
    bcd_d      = bcd_q;
    neg_d      = neg_q;
    ovf_d      = ovf_q;
    cur_sel_d  = cur_sel_q;
    upd_d      = 1'b0;
    start_s    = 1'b0;
    case (state_q)
      IDLE: state_d = LOAD;
      LOAD: begin
        start_s    = 1'b1;
        sel_d      = load_sel_s;
        neg_pend_d = load_neg_s;
        state_d    = CONV;
      end
      CONV: begin
        if (core_done_s) begin
          state_d = DONE;
        end else if (!core_busy_s) begin
          state_d = LOAD;
        end else begin
          state_d = CONV;
        end
      end
      DONE: begin
        bcd_d     = disp_bcd_s;
        neg_d     = neg_pend_q;
        ovf_d     = acc_ovf_s;
        cur_sel_d = sel_q;
        upd_d     = 1'b1;
        cnt_d     = 32'd0;
        state_d   = WAIT;
      end
      WAIT: begin
        if (hold) begin
          cnt_d = cnt_q;
        end else if (cnt_q + 32'd1 >= 32'(DWELL)) begin
          cnt_d   = 32'd0;
          state_d = LOAD;
          if (auto_mode) begin
            cand_d = rr_next_s;
          end else begin
            cand_d = cand_q;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == LOAD) || (state_d == CONV) || (state_d == DONE);
  end

  // Scheduler state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 32'd0;
      cand_q     <= '0;
      sel_q      <= '0;
      neg_pend_q <= 1'b0;
      bcd_q      <= 32'd0;
      neg_q      <= 1'b0;
      ovf_q      <= 1'b0;
      cur_sel_q  <= '0;
      upd_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cand_q     <= cand_d;
      sel_q      <= sel_d;
      neg_pend_q <= neg_pend_d;
      bcd_q      <= bcd_d;
      neg_q      <= neg_d;
      ovf_q      <= ovf_d;
      cur_sel_q  <= cur_sel_d;
      upd_q      <= upd_d;
      busy_q     <= busy_d;
    end
  end

  assign bcd     = bcd_q;
  assign neg     = neg_q;
  assign ovf     = ovf_q;
  assign cur_sel = cur_sel_q;
  assign upd     = upd_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_display_scheduler.sv
// Directed self-checking bench for display_scheduler (NSRC=4, DWELL=4, SIGNED=1).
module tb_display_scheduler;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] src_data;
  logic [3:0]   src_valid;
  logic         auto_mode;
  logic [1:0]   man_sel;
  logic         hold;
  logic [31:0]  bcd;
  logic         neg, ovf, upd, busy;
  logic [1:0]   cur_sel;

  int checks = 0;
  int errors = 0;
  int n;
  logic [31:0] exp_one, exp_seven, exp_42, exp_zero;
  logic [1:0]  exp_rr [4];

  always #5 clk = ~clk;

  display_scheduler #(.NSRC(4), .DWELL(4), .SIGNED(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .src_data  (src_data),
    .src_valid (src_valid),
    .auto_mode (auto_mode),
    .man_sel   (man_sel),
    .hold      (hold),
    .bcd       (bcd),
    .neg       (neg),
    .ovf       (ovf),
    .cur_sel   (cur_sel),
    .upd       (upd),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Counts rising edges until upd is seen (sampled 1 time unit after the edge), bounded.
  task automatic wait_upd(output int cnt);
    cnt = 0;
    do begin
      @(posedge clk);
      #1;
      cnt++;
    end while (upd !== 1'b1 && cnt < 200);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_bcd"}, bcd, 32'd0);
    chk({tag, "_neg"}, 32'(neg), 32'd0);
    chk({tag, "_ovf"}, 32'(ovf), 32'd0);
    chk({tag, "_sel"}, 32'(cur_sel), 32'd0);
    chk({tag, "_upd"}, 32'(upd), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
`ifdef LEADING_BLANK_EN
    exp_one   = 32'hFFFFFFF1;
    exp_seven = 32'hFFFFFFF7;
    exp_42    = 32'hFFFFFF42;
    exp_zero  = 32'hFFFFFFF0;
`else
    exp_one   = 32'h00000001;
    exp_seven = 32'h00000007;
    exp_42    = 32'h00000042;
    exp_zero  = 32'h00000000;
`endif
    exp_rr[0] = 2'd1; exp_rr[1] = 2'd3; exp_rr[2] = 2'd1; exp_rr[3] = 2'd3;

    rst       = 1'b1;
    src_data  = 128'd0;
    src_data[32*1 +: 32] = 32'd12345678;
    src_valid = 4'b0000;
    auto_mode = 1'b0;
    man_sel   = 2'd1;
    hold      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");

    // Manual source 1, first refresh after reset release.
    rst = 1'b0;
    wait_upd(n);
    chk("first_latency", 32'(n), 32'd35);
    chk("man1_bcd", bcd, 32'h12345678);
    chk("man1_neg", 32'(neg), 32'd0);
    chk("man1_ovf", 32'(ovf), 32'd0);
    chk("man1_sel", 32'(cur_sel), 32'd1);
    chk("man1_busy", 32'(busy), 32'd0);

    // Negative one on source 0.
    man_sel = 2'd0;
    src_data[32*0 +: 32] = 32'hFFFFFFFF;
    wait_upd(n);
    chk("period", 32'(n), 32'd38);
    chk("m1_bcd", bcd, exp_one);
    chk("m1_neg", 32'(neg), 32'd1);
    chk("m1_ovf", 32'(ovf), 32'd0);
    chk("m1_sel", 32'(cur_sel), 32'd0);

    // Most negative value: magnitude 2147483648 overflows eight digits.
    src_data[32*0 +: 32] = 32'h80000000;
    wait_upd(n);
    chk("min_gap", 32'(n), 32'd38);
    chk("min_bcd", bcd, 32'h47483648);
    chk("min_neg", 32'(neg), 32'd1);
    chk("min_ovf", 32'(ovf), 32'd1);

    // Auto round-robin over sources 1 and 3, starting after cur_sel 0.
    auto_mode = 1'b1;
    src_valid = 4'b1010;
    src_data[32*3 +: 32] = 32'd7;
    for (int i = 0; i < 4; i++) begin
      wait_upd(n);
      chk("rr_gap", 32'(n), 32'd38);
      chk("rr_sel", 32'(cur_sel), 32'(exp_rr[i]));
      chk("rr_bcd", bcd, (exp_rr[i] == 2'd1) ? 32'h12345678 : exp_seven);
      chk("rr_neg", 32'(neg), 32'd0);
    end

    // No valid source: current one is reconverted.
    src_valid = 4'b0000;
    for (int i = 0; i < 2; i++) begin
      wait_upd(n);
      chk("nov_gap", 32'(n), 32'd38);
      chk("nov_sel", 32'(cur_sel), 32'd3);
    end

    // Manual source 2 with hold for 20 cycles during WAIT.
    auto_mode = 1'b0;
    man_sel   = 2'd2;
    src_data[32*2 +: 32] = 32'd42;
    hold = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    hold = 1'b0;
    wait_upd(n);
    chk("hold_gap", 32'(n + 20), 32'd58);
    chk("hold_bcd", bcd, exp_42);
    chk("hold_sel", 32'(cur_sel), 32'd2);

    // Source change in the middle of a conversion must not disturb it.
    repeat (10) @(posedge clk);
    #1;
    src_data[32*2 +: 32] = 32'd0;
    wait_upd(n);
    chk("midconv_gap", 32'(n), 32'd28);
    chk("midconv_bcd", bcd, exp_42);
    wait_upd(n);
    chk("zero_gap", 32'(n), 32'd38);
    chk("zero_bcd", bcd, exp_zero);
    chk("zero_neg", 32'(neg), 32'd0);
    chk("zero_sel", 32'(cur_sel), 32'd2);

    // Reset pulse in the middle of a conversion.
    man_sel = 2'd1;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_zero("midrst");
    rst = 1'b0;
    wait_upd(n);
    chk("rst_latency", 32'(n), 32'd35);
    chk("rst_bcd", bcd, 32'h12345678);
    chk("rst_sel", 32'(cur_sel), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
